// File: rtl/bus_switch_pkg.sv
// Shared types for the bus switch sequencer: segment codes, FSM states,
// per-switch drive direction and the two-switch route.
package bus_switch_pkg;

  localparam logic [1:0] SEG_ALU = 2'd0;
  localparam logic [1:0] SEG_REG = 2'd1;
  localparam logic [1:0] SEG_PIN = 2'd2;
  localparam logic [1:0] SEG_ILL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  typedef struct packed {
    dir_e sw1_dir;
    dir_e sw2_dir;
  } route_t;

endpackage

// File: rtl/bus_switch_route.sv
// Combinational route decode: source/destination segment and mask request
// to per-switch direction, plus an illegal-request flag.
module bus_switch_route
  import bus_switch_pkg::*;
(
  input  logic [1:0] src_i,
  input  logic [1:0] dst_i,
  input  logic       mask543_i,
  output route_t     route_o,
  output logic       illegal_o
);

  route_t rt;
  logic   bad;

  always_comb begin
    rt  = '{sw1_dir: DIR_NONE, sw2_dir: DIR_NONE};
    bad = 1'b0;
    if (src_i == SEG_ILL || dst_i == SEG_ILL || src_i == dst_i) begin
      bad = 1'b1;
    end else if (src_i < dst_i) begin
      if (src_i == SEG_ALU) rt.sw1_dir = DIR_DOWN;
      if (dst_i == SEG_PIN) rt.sw2_dir = DIR_DOWN;
    end else begin
      if (dst_i == SEG_ALU) rt.sw1_dir = DIR_UP;
      if (src_i == SEG_PIN) rt.sw2_dir = DIR_UP;
    end
    // [5:3] masking only makes sense while SW1 drives downstream
    if (mask543_i && rt.sw1_dir != DIR_DOWN) bad = 1'b1;
    if (bad) rt = '{sw1_dir: DIR_NONE, sw2_dir: DIR_NONE};
    route_o   = rt;
    illegal_o = bad;
  end

endmodule

// File: rtl/bus_switch_seq.sv
// Bus switch sequencer: accepts a transfer request, inserts a break-before-make
// turnaround when a switch reverses, then drives the routed switches hold+1 cycles.
module bus_switch_seq
  import bus_switch_pkg::*;
#(
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_W      = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req,
  input  logic [1:0]        src,
  input  logic [1:0]        dst,
  input  logic              mask543,
  input  logic [HOLD_W-1:0] hold,
  input  logic              abort,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic              done,
  output logic              ctl_sw_1u,
  output logic              ctl_sw_1d,
  output logic              ctl_sw_2u,
  output logic              ctl_sw_2d,
  output logic              ctl_sw_mask543_en
);

  localparam int CNT_W = (HOLD_W > 2) ? HOLD_W : 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  route_t            route_q, route_d;
  logic              mask_q, mask_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  dir_e              mem1_q, mem2_q;
  logic              sw1u_q, sw1d_q, sw2u_q, sw2d_q, msk_q, done_q;

  route_t            req_route;
  logic              req_illegal;
  logic              turn_needed;
  logic              drv_d;

  bus_switch_route u_route (
    .src_i     (src),
    .dst_i     (dst),
    .mask543_i (mask543),
    .route_o   (req_route),
    .illegal_o (req_illegal)
  );

  assign turn_needed =
    (req_route.sw1_dir != DIR_NONE && mem1_q != DIR_NONE && mem1_q != req_route.sw1_dir) ||
    (req_route.sw2_dir != DIR_NONE && mem2_q != DIR_NONE && mem2_q != req_route.sw2_dir);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    route_d = route_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    ack     = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          ack = 1'b1;
          err = req_illegal;
          if (!req_illegal) begin
            route_d = req_route;
            mask_d  = mask543;
            hold_d  = hold;
            if (turn_needed) begin
              state_d = ST_TURN;
              cnt_d   = CNT_W'(TURN_CYCLES - 1);
            end else begin
              state_d = ST_DRIVE;
              cnt_d   = CNT_W'(hold);
            end
          end
        end
      end
      ST_TURN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_DRIVE;
          cnt_d   = CNT_W'(hold_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (abort || cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they line up with the state register.
  assign drv_d = (state_d == ST_DRIVE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      route_q <= '{sw1_dir: DIR_NONE, sw2_dir: DIR_NONE};
      mask_q  <= 1'b0;
      hold_q  <= '0;
      mem1_q  <= DIR_NONE;
      mem2_q  <= DIR_NONE;
      sw1u_q  <= 1'b0;
      sw1d_q  <= 1'b0;
      sw2u_q  <= 1'b0;
      sw2d_q  <= 1'b0;
      msk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      route_q <= route_d;
      mask_q  <= mask_d;
      hold_q  <= hold_d;
      if (drv_d && state_q != ST_DRIVE) begin
        if (route_d.sw1_dir != DIR_NONE) mem1_q <= route_d.sw1_dir;
        if (route_d.sw2_dir != DIR_NONE) mem2_q <= route_d.sw2_dir;
      end
      sw1u_q <= drv_d && route_d.sw1_dir == DIR_UP;
      sw1d_q <= drv_d && route_d.sw1_dir == DIR_DOWN;
      sw2u_q <= drv_d && route_d.sw2_dir == DIR_UP;
      sw2d_q <= drv_d && route_d.sw2_dir == DIR_DOWN;
      msk_q  <= drv_d && mask_d && route_d.sw1_dir == DIR_DOWN;
      done_q <= drv_d && cnt_d == '0;
    end
  end

  assign busy              = (state_q != ST_IDLE);
  assign done              = done_q;
  assign ctl_sw_1u         = sw1u_q;
  assign ctl_sw_1d         = sw1d_q;
  assign ctl_sw_2u         = sw2u_q;
  assign ctl_sw_2d         = sw2d_q;
  assign ctl_sw_mask543_en = msk_q;

endmodule

// File: tb/tb_bus_switch_seq.sv
// Directed bench for bus_switch_seq; output vector per cycle is
// {ack, err, busy, done, 1u, 1d, 2u, 2d, mask543_en}.
module tb_bus_switch_seq;
  import bus_switch_pkg::*;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       req = 1'b0;
  logic [1:0] src = 2'd0;
  logic [1:0] dst = 2'd0;
  logic       mask543 = 1'b0;
  logic [1:0] hold = 2'd0;
  logic       abort = 1'b0;
  logic       ack, err, busy, done;
  logic       sw1u, sw1d, sw2u, sw2d, msk;
  logic [8:0] ov;

  logic [1:0] c_src = 2'd0;
  logic [1:0] c_dst = 2'd0;
  logic       c_mask = 1'b0;
  route_t     c_route;
  logic       c_ill;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_switch_seq #(.TURN_CYCLES(1), .HOLD_W(2)) dut (
    .clk               (clk),
    .nreset            (nreset),
    .req               (req),
    .src               (src),
    .dst               (dst),
    .mask543           (mask543),
    .hold              (hold),
    .abort             (abort),
    .ack               (ack),
    .err               (err),
    .busy              (busy),
    .done              (done),
    .ctl_sw_1u         (sw1u),
    .ctl_sw_1d         (sw1d),
    .ctl_sw_2u         (sw2u),
    .ctl_sw_2d         (sw2d),
    .ctl_sw_mask543_en (msk)
  );

  bus_switch_route u_chk (
    .src_i     (c_src),
    .dst_i     (c_dst),
    .mask543_i (c_mask),
    .route_o   (c_route),
    .illegal_o (c_ill)
  );

  assign ov = {ack, err, busy, done, sw1u, sw1d, sw2u, sw2d, msk};

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
      $error("tag=%s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ask(input logic [1:0] s, input logic [1:0] d, input logic m, input logic [1:0] h);
    req = 1'b1;
    src = s;
    dst = d;
    mask543 = m;
    hold = h;
  endtask

  task automatic route_chk(input string tag, input logic [1:0] s, input logic [1:0] d,
                           input logic m, input logic [4:0] exp);
    c_src = s;
    c_dst = d;
    c_mask = m;
    #1;
    chk(tag, 9'({c_route, c_ill}), 9'(exp));
  endtask

  initial begin
    // route decode: {sw1_dir, sw2_dir, illegal}, NONE=0 UP=1 DOWN=2
    route_chk("rt_0to2", 2'd0, 2'd2, 1'b0, 5'b10100);
    route_chk("rt_2to0", 2'd2, 2'd0, 1'b0, 5'b01010);
    route_chk("rt_1to2", 2'd1, 2'd2, 1'b0, 5'b00100);
    route_chk("rt_3to1", 2'd3, 2'd1, 1'b0, 5'b00001);
    route_chk("rt_2to1_mask", 2'd2, 2'd1, 1'b1, 5'b00001);
    route_chk("rt_0to1_mask", 2'd0, 2'd1, 1'b1, 5'b10000);

    #1;
    chk("reset_state", ov, 9'b000000000);
    cyc(); cyc();
    nreset = 1'b1;
    cyc();
    #2 chk("idle_after_reset", ov, 9'b000000000);

    // 0->2 hold=1, no turnaround from reset
    cyc(); ask(2'd0, 2'd2, 1'b0, 2'd1);
    #2 chk("t1_ack", ov, 9'b100000000);
    cyc(); req = 1'b0;
    #2 chk("t1_drv1", ov, 9'b001001010);
    cyc();
    #2 chk("t1_drv2_done", ov, 9'b001101010);
    cyc();
    #2 chk("t1_idle", ov, 9'b000000000);

    // 0->1 hold=0 then 1->0 hold=0: SW1 reverses -> one TURN cycle
    cyc(); ask(2'd0, 2'd1, 1'b0, 2'd0);
    #2 chk("t2a_ack", ov, 9'b100000000);
    cyc(); req = 1'b0;
    #2 chk("t2a_drv", ov, 9'b001101000);
    cyc(); ask(2'd1, 2'd0, 1'b0, 2'd0);
    #2 chk("t2b_ack", ov, 9'b100000000);
    cyc(); req = 1'b0;
    #2 chk("t2b_turn", ov, 9'b001000000);
    cyc();
    #2 chk("t2b_drv", ov, 9'b001110000);
    cyc();
    #2 chk("t2b_idle", ov, 9'b000000000);

    // rejected requests
    cyc(); ask(2'd1, 2'd1, 1'b0, 2'd0);
    #2 chk("t3_same_err", ov, 9'b110000000);
    cyc(); req = 1'b0;
    #2 chk("t3_same_after", ov, 9'b000000000);
    cyc(); ask(2'd2, 2'd1, 1'b1, 2'd0);
    #2 chk("t3_mask_err", ov, 9'b110000000);
    cyc(); req = 1'b0; mask543 = 1'b0;
    #2 chk("t3_mask_after", ov, 9'b000000000);

    // 0->1 mask hold=3: SW1 last drove up, so a TURN cycle precedes 4 drive cycles
    cyc(); ask(2'd0, 2'd1, 1'b1, 2'd3);
    #2 chk("t4_ack", ov, 9'b100000000);
    cyc(); req = 1'b0; mask543 = 1'b0;
    #2 chk("t4_turn", ov, 9'b001000000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #2 chk($sformatf("t4_drv%0d", i), ov, 9'b001001001);
    end
    cyc();
    #2 chk("t4_drv_last", ov, 9'b001101001);
    cyc();
    #2 chk("t4_idle", ov, 9'b000000000);

    // abort in second DRIVE cycle
    cyc(); ask(2'd0, 2'd1, 1'b0, 2'd3);
    #2 chk("t5_ack", ov, 9'b100000000);
    cyc(); req = 1'b0;
    #2 chk("t5_drv1", ov, 9'b001001000);
    cyc(); abort = 1'b1;
    #2 chk("t5_drv2", ov, 9'b001001000);
    cyc(); abort = 1'b0;
    #2 chk("t5_aborted", ov, 9'b000000000);
    cyc(); abort = 1'b1;
    #2 chk("t5_idle_abort", ov, 9'b000000000);
    abort = 1'b0;

    // asynchronous reset mid-DRIVE clears outputs and direction memory
    cyc(); ask(2'd0, 2'd1, 1'b0, 2'd3);
    #2 chk("t6_ack", ov, 9'b100000000);
    cyc(); req = 1'b0;
    #2 chk("t6_drv1", ov, 9'b001001000);
    #1 nreset = 1'b0;
    #1 chk("t6_async_rst", ov, 9'b000000000);
    cyc(); nreset = 1'b1;
    cyc(); ask(2'd1, 2'd0, 1'b0, 2'd0);
    #2 chk("t6_ack_after_rst", ov, 9'b100000000);
    cyc(); req = 1'b0;
    #2 chk("t6_no_turn_drv", ov, 9'b001110000);
    cyc();
    #2 chk("t6_idle", ov, 9'b000000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_switch_seq.md
# bus_switch_seq

Sequencer that generates the data bus switch controls (SW1/SW2 upstream/downstream and the [5:3] mask enable) from a transfer request. It accepts a request for one transfer between two data bus segments, enables the required switches in the correct direction for a programmable number of cycles, and enforces break-before-make with a turnaround gap whenever a switch reverses direction. It sits between the execute/sequencer logic and the bus switch control inputs.

## Interface
- TURN_CYCLES, 1: dead cycles inserted when any used switch reverses direction (legal 1..3).
- HOLD_W, 2: width of the hold field; drive lasts hold+1 cycles.
- clk  in  1  CPU clock.
- nreset  in  1  asynchronous, active-low reset.
- req  in  1  transfer request; sampled only in IDLE.
- src  in  2  source segment: 0 = ALU side, 1 = register side, 2 = pin side; 3 is illegal.
- dst  in  2  destination segment, same encoding.
- mask543  in  1  request [5:3] masking; legal only when SW1 drives downstream.
- hold  in  HOLD_W  drive length minus one.
- abort  in  1  synchronous abort of the current transfer.
- ack  out  1  one-cycle pulse: request accepted (also on rejected requests).
- err  out  1  one-cycle pulse with ack: request rejected.
- busy  out  1  high from the cycle after acceptance until the return to IDLE.
- done  out  1  one-cycle pulse in the last DRIVE cycle.
- ctl_sw_1u, ctl_sw_1d, ctl_sw_2u, ctl_sw_2d  out  1 each  switch controls, registered.
- ctl_sw_mask543_en  out  1  mask enable, registered; high only together with ctl_sw_1d.

## Operation
- Switch map: SW1 joins segments 0–1, SW2 joins 1–2. "d" drives toward the higher segment, "u" drives toward the lower segment.
- Route: 0→1 = 1d; 0→2 = 1d+2d; 1→2 = 2d; 1→0 = 1u; 2→1 = 2u; 2→0 = 2u+1u.
- Reject if src==dst, src==3, dst==3, or mask543=1 without 1d in the route. A rejected request produces ack=err=1 and the block stays in IDLE.
- States: IDLE, TURN, DRIVE.
- IDLE + req, valid: ack=1. The block latches route, mask and hold. Next state is TURN if any routed switch's remembered direction is opposite to the new direction; otherwise next state is DRIVE.
- TURN: all switch outputs 0 for TURN_CYCLES cycles, then DRIVE.
- DRIVE: the routed outputs are 1 for exactly hold+1 cycles. done=1 in the last of those cycles, then the block returns to IDLE.
- On DRIVE entry, each routed switch's last-direction memory (none/up/down) is updated. Unrouted switches keep their memory.
- abort in TURN or DRIVE: next cycle is IDLE with all outputs 0. No done pulse. Direction memory keeps any update already made. abort in IDLE is ignored.
- Invariant: 1u and 1d are never both high; 2u and 2d are never both high. mask543_en is never high without 1d.

## Timing
- Reset: state IDLE, every output 0, all direction memories = none.
- Accept in cycle N → first DRIVE cycle at N+1 without turnaround, or N+1+TURN_CYCLES with turnaround.
- After DRIVE, IDLE lasts at least 1 cycle with all switches off. The earliest next ack is the cycle after the last DRIVE cycle, so back-to-back transfers have a 1-cycle gap.
- req while busy is ignored. The requester holds req until ack, and must deassert it in the cycle after ack or a new transfer is accepted.
- Reset asserted mid-transfer: outputs drop to 0 asynchronously and direction memory clears.

## Structure
- Shared package bus_switch_pkg:
  - segment encoding constants;
  - state enum (IDLE/TURN/DRIVE);
  - direction enum (NONE/UP/DOWN);
  - a route struct {sw1_dir, sw2_dir}.
- One sub-module, bus_switch_route: combinational src/dst/mask → route + illegal flag. Reused by the checker in the bench.
- Single counter, shared between TURN and DRIVE and reloaded on each state entry.

## Test plan
- After reset: req src=0 dst=2 hold=1 → ack in cycle N. ctl_sw_1d and ctl_sw_2d high in N+1 and N+2, done in N+2. All outputs 0 in N+3.
- Request 0→1 hold=0, then 1→0 hold=0 → second transfer has one TURN cycle, all outputs 0. ctl_sw_1u high for exactly 1 cycle.
- src=1 dst=1 → ack=err=1 in the same cycle, busy stays 0, switches stay 0. Repeat with src=2 dst=1 mask543=1 → err.
- src=0 dst=1 mask543=1 hold=3 → ctl_sw_1d and ctl_sw_mask543_en high 4 cycles, then drop together.
- abort in the 2nd DRIVE cycle of hold=3 → outputs 0 next cycle, no done, busy low next cycle.
- nreset pulsed low mid-DRIVE → outputs 0 immediately. A following 1→0 request gets no TURN cycle, because direction memory was cleared.
